// File: rtl/temp_digit_seq.sv
// ============================================================================
// Module  : temp_digit_seq
// Brief   : Tens/ones/blank digit sequencer driving a shared BCD converter.
//           Optional leading-zero blank: define TEMP_DIGIT_SEQ_LZ_BLANK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module temp_digit_seq #(
    parameter int DWELL_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [6:0]         i_value,
    input  logic               i_valid,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [6:0]         o_bin,
    output logic               o_tens,
    output logic               o_ones,
    input  logic [3:0]         i_dec,
    output logic [3:0]         o_digit,
    output logic               o_strobe,
    output logic               o_busy
);

    localparam logic [3:0] C_BLANK = 4'd10;
    localparam logic [6:0] C_MAX   = 7'd99;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TENS  = 2'd1,
        S_ONES  = 2'd2,
        S_BLANK = 2'd3
    } state_t;

    state_t             r_state;
    state_t             r_prev;
    state_t             w_next;
    logic [DWELL_W-1:0] r_cnt;
    logic [6:0]         r_bin;
    logic [6:0]         r_pend;
    logic               r_pend_vld;
    logic [3:0]         r_digit;
    logic               r_strobe;

    logic [6:0]         w_clamp;
    logic               w_start;
    logic               w_wrap;
    logic               w_load;
    logic [3:0]         w_digit;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_valid)        w_next = S_TENS;
            S_TENS:  if (r_cnt == '0)    w_next = S_ONES;
            S_ONES:  if (r_cnt == '0)    w_next = S_BLANK;
            S_BLANK: if (r_cnt == '0)    w_next = S_TENS;
            default:                     w_next = S_IDLE;
        endcase
        if (!i_en) begin
            w_next = S_IDLE;
        end
    end

    always_comb begin
        w_clamp = (i_value > C_MAX) ? C_MAX : i_value;
        w_start = (r_state == S_IDLE)  && (w_next == S_TENS);
        w_wrap  = (r_state == S_BLANK) && (w_next == S_TENS);
        w_load  = (w_next != r_state)  && (w_next != S_IDLE);
    end

    always_comb begin
`ifdef TEMP_DIGIT_SEQ_LZ_BLANK_EN
        w_digit = ((r_state == S_TENS) && (i_dec == 4'd0)) ? C_BLANK : i_dec;
`else
        w_digit = i_dec;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_prev  <= S_IDLE;
        end else begin
            r_state <= w_next;
            r_prev  <= r_state;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= i_dwell;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A strobe landing on the wrap edge bypasses the pending register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bin      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            if (w_start) begin
                r_bin <= w_clamp;
            end else if (w_wrap) begin
                if (i_valid) begin
                    r_bin <= w_clamp;
                end else if (r_pend_vld) begin
                    r_bin <= r_pend;
                end
            end

            if (!i_en || w_wrap) begin
                r_pend_vld <= 1'b0;
            end else if (i_valid && (r_state != S_IDLE)) begin
                r_pend     <= w_clamp;
                r_pend_vld <= 1'b1;
            end
        end
    end

    // Strobe follows the state change by one cycle so it lines up with o_digit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_digit  <= C_BLANK;
            r_strobe <= 1'b0;
        end else begin
            r_digit  <= w_digit;
            r_strobe <= (r_state != r_prev);
        end
    end

    assign o_bin    = r_bin;
    assign o_tens   = (r_state == S_TENS);
    assign o_ones   = (r_state == S_ONES);
    assign o_digit  = r_digit;
    assign o_strobe = r_strobe;
    assign o_busy   = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_temp_digit_seq.sv
// ============================================================================
// Module  : tb_temp_digit_seq
// Brief   : Directed self-checking bench for temp_digit_seq.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_temp_digit_seq;

    localparam int DWELL_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [6:0]         value;
    logic               valid;
    logic [DWELL_W-1:0] dwell;
    logic [6:0]         bin;
    logic               tens;
    logic               ones;
    logic [3:0]         dec;
    logic [3:0]         digit;
    logic               strobe;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    temp_digit_seq #(.DWELL_W(DWELL_W)) u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (en),
        .i_value  (value),
        .i_valid  (valid),
        .i_dwell  (dwell),
        .o_bin    (bin),
        .o_tens   (tens),
        .o_ones   (ones),
        .i_dec    (dec),
        .o_digit  (digit),
        .o_strobe (strobe),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    // Converter model
    always_comb begin
        if (tens)      dec = 4'(bin / 7'd10);
        else if (ones) dec = 4'(bin % 7'd10);
        else           dec = 4'd10;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_digit"},  int'(digit),  10);
        check_eq({tag, "_strobe"}, int'(strobe), 0);
        check_eq({tag, "_busy"},   int'(busy),   0);
        check_eq({tag, "_tens"},   int'(tens),   0);
        check_eq({tag, "_ones"},   int'(ones),   0);
        check_eq({tag, "_bin"},    int'(bin),    0);
    endtask

    int exp42 [12] = '{4, 4, 4, 2, 2, 2, 10, 10, 10, 4, 4, 4};
    int k;
    int n;
    int lz_tens;

    initial begin
`ifdef TEMP_DIGIT_SEQ_LZ_BLANK_EN
        lz_tens = 10;
`else
        lz_tens = 0;
`endif
        rst = 1'b1; en = 1'b0; valid = 1'b0; value = '0; dwell = '0;
        step(); step();
        check_reset_outputs("rst");

        rst = 1'b0;
        repeat (10) step();
        check_reset_outputs("idle10");

        // Strobe with display disabled is dropped
        value = 7'd50; valid = 1'b1;
        step();
        valid = 1'b0;
        check_eq("drop_busy", int'(busy), 0);
        check_eq("drop_bin",  int'(bin),  0);

        // 42 with dwell 2
        en = 1'b1; dwell = 4'd2; value = 7'd42; valid = 1'b1;
        step();
        valid = 1'b0;
        check_eq("s42_tens",   int'(tens),   1);
        check_eq("s42_busy",   int'(busy),   1);
        check_eq("s42_bin",    int'(bin),    42);
        check_eq("s42_strobe", int'(strobe), 0);
        for (int i = 0; i < 12; i++) begin
            step();
            check_eq($sformatf("s42_digit%0d", i),  int'(digit),  exp42[i]);
            check_eq($sformatf("s42_strobe%0d", i), int'(strobe), (i % 3 == 0) ? 1 : 0);
        end

        // Two updates during ONES: last one wins at the next TENS
        check_eq("pend_in_ones", int'(ones), 1);
        value = 7'd55; valid = 1'b1;
        step();
        value = 7'd63;
        step();
        valid = 1'b0;
        check_eq("pend_bin_hold", int'(bin), 42);
        k = 0;
        while (!tens && k < 20) begin
            step();
            k++;
        end
        check_eq("pend_tens_reached", int'(tens), 1);
        check_eq("pend_bin_new", int'(bin), 63);
        step();
        check_eq("pend_digit6",  int'(digit),  6);
        check_eq("pend_strobe",  int'(strobe), 1);

        // Disable mid-TENS
        en = 1'b0;
        step();
        check_eq("dis_busy",  int'(busy),  0);
        check_eq("dis_tens",  int'(tens),  0);
        check_eq("dis_digit_prev", int'(digit), 6);
        step();
        check_eq("dis_digit",  int'(digit),  10);
        check_eq("dis_strobe", int'(strobe), 1);
        check_eq("dis_bin",    int'(bin),    63);
        step();
        check_eq("idle_no_strobe", int'(strobe), 0);

        // Value 7 with dwell 0, then a strobe on the wrap edge
        en = 1'b1; dwell = 4'd0; value = 7'd7; valid = 1'b1;
        step();
        valid = 1'b0;
        check_eq("s7_bin", int'(bin), 7);
        step();
        check_eq("s7_tens_digit", int'(digit), lz_tens);
        step();
        check_eq("s7_ones_digit", int'(digit), 7);
        value = 7'd88; valid = 1'b1;
        step();
        valid = 1'b0;
        check_eq("wrap_bin",   int'(bin),   88);
        check_eq("wrap_tens",  int'(tens),  1);
        check_eq("wrap_digit", int'(digit), 10);
        step();
        check_eq("s88_tens_digit", int'(digit), 8);
        step();
        check_eq("s88_ones_digit", int'(digit), 8);

        // Clamp 120 to 99
        en = 1'b0;
        step(); step();
        en = 1'b1; value = 7'd120; valid = 1'b1;
        step();
        valid = 1'b0;
        check_eq("clamp_bin", int'(bin), 99);
        step();
        check_eq("clamp_d0", int'(digit), 9);
        step();
        check_eq("clamp_d1", int'(digit), 9);
        step();
        check_eq("clamp_d2", int'(digit), 10);

        // Asynchronous reset mid-ONES
        step();
        check_eq("arst_in_ones", int'(ones), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        en = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Maximum dwell must not wrap: 16-cycle phase
        en = 1'b1; dwell = 4'd15; value = 7'd42; valid = 1'b1;
        step();
        valid = 1'b0;
        n = 0;
        step();
        while (digit == 4'd4 && n < 40) begin
            n++;
            step();
        end
        check_eq("maxdwell_len",   n, 16);
        check_eq("maxdwell_next",  int'(digit), 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
